// File: rtl/regfile_writeback_if.sv
// Writeback request bus between the execution units / issue stage and the
// register-file write front end.
//
// Handshake: a source raises src_valid[k] together with src_addr[k] and
// src_data[k] and holds all three stable until it sees src_ready[k]=1. A
// transfer happens at the rising clock edge where valid and ready are both 1.
// Ready is only ever raised for a source whose valid is already high.
// iss_valid/iss_addr is a single-cycle strobe with no ready: issue marks a
// destination register as having a write in flight.
//
// Signals:
//   src_valid [N_SRC]        per-source writeback request
//   src_ready [N_SRC]        per-source accept (driven by the write front end)
//   src_addr  [N_SRC] x 5    destination register index per source
//   src_data  [N_SRC] x XLEN writeback data per source
//   iss_valid                issue marks iss_addr as pending
//   iss_addr  5              destination being issued
interface regfile_writeback_if #(
  parameter int N_SRC = 3,
  parameter int XLEN  = 32
);
  logic [N_SRC-1:0] src_valid;
  logic [N_SRC-1:0] src_ready;
  logic [4:0]       src_addr [N_SRC];
  logic [XLEN-1:0]  src_data [N_SRC];
  logic             iss_valid;
  logic [4:0]       iss_addr;

  modport master (
    output src_valid,
    output src_addr,
    output src_data,
    output iss_valid,
    output iss_addr,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_addr,
    input  src_data,
    input  iss_valid,
    input  iss_addr,
    output src_ready
  );
endinterface

// File: rtl/regfile_writeback.sv
// Write-side front end of the 32-entry register file (r0 hardwired zero,
// r1-r15 general, f0-f15 mapped to r16-r31).
//
// Arbitrates writeback requests from N_SRC execution units round-robin, one
// write per cycle, and presents the winner to the register file through a
// single registered stage (latency 1). Keeps a pending-write scoreboard that
// issue logic uses to stall on in-flight destinations.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   bus          writeback/issue bus (slave side), see regfile_writeback_if
//   outreg_data  [0:31] x XLEN data presented to each register
//   outreg_en    32-bit one-hot write enable, bit i writes register i
//   busy         scoreboard, bit i = write to register i outstanding
//   rr_ptr_o     round-robin pointer (debug visibility of arbiter state)
module regfile_writeback #(
  parameter  int N_SRC = 3,
  parameter  int XLEN  = 32,
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_writeback_if.slave   bus,
  output logic [XLEN-1:0]      outreg_data [0:31],
  output logic [31:0]          outreg_en,
  output logic [31:0]          busy,
  output logic [PTR_W-1:0]     rr_ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [31:0]      en_q, en_d;
  logic [31:0]      busy_q, busy_d;
  logic [XLEN-1:0]  data_q [0:31];

  logic             grant_vld;
  logic [PTR_W-1:0] grant_idx;
  logic             xfer;
  logic [4:0]       wr_addr;
  logic [XLEN-1:0]  wr_data;
  logic             wr_en;

  // Round-robin search starting at ptr_q, wrapping modulo N_SRC.
  always_comb begin
    logic [PTR_W:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_SRC)) begin
        cand = cand - (PTR_W+1)'(N_SRC);
      end
      if (!grant_vld && bus.src_valid[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Ready is masked by rst so nothing is accepted while reset is held.
  assign xfer    = grant_vld && !rst;
  assign wr_addr = bus.src_addr[grant_idx];
  assign wr_data = bus.src_data[grant_idx];
  // r0 writes complete the handshake but never reach the register file.
  assign wr_en   = xfer && (wr_addr != 5'd0);

  always_comb begin
    bus.src_ready = '0;
    if (xfer) begin
      bus.src_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_comb begin
    en_d = '0;
    if (wr_en) begin
      en_d[wr_addr] = 1'b1;
    end
  end

  // Clear before set: an issue to the same register in the same cycle
  // belongs to a newer instruction, so its pending mark must survive.
  always_comb begin
    busy_d = busy_q;
    if (xfer) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      en_q   <= '0;
      busy_q <= '0;
      for (int r = 0; r < 32; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      if (wr_en) begin
        data_q[wr_addr] <= wr_data;
      end
    end
  end

  assign outreg_en   = en_q;
  assign busy        = busy_q;
  assign rr_ptr_o    = ptr_q;
  assign outreg_data = data_q;

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end of the 32-entry register file (r0 zero, r1-r15 general, f0-f15 as r16-r31).
- Accepts writeback requests from N_SRC execution units over valid/ready handshakes and arbitrates them round-robin, one write per cycle.
- Drives the register file's per-register data array and one-hot enable vector.
- Maintains a pending-write scoreboard so issue logic can stall on in-flight destinations.

Parameters:
- N_SRC, 3, number of writeback sources: 0=ALU, 1=FPU, 2=LSU.
- XLEN, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- src_valid  input  N_SRC  per-source writeback request.
- src_ready  output  N_SRC  per-source accept; combinational from the grant.
- src_addr  input  N_SRC x 5  destination register index per source.
- src_data  input  N_SRC x XLEN  writeback data per source.
- iss_valid  input  1  issue stage marks a destination as pending.
- iss_addr  input  5  destination being issued.
- outreg_data  output  32 x XLEN  unpacked array [0:31]; data presented to each register.
- outreg_en  output  32  one-hot write enable; bit i writes register i.
- busy  output  32  scoreboard; bit i = write to register i outstanding.

Behaviour:
- Reset (async, immediate): outreg_en=0, all outreg_data entries=0, busy=0, round-robin pointer=0, src_ready=0 while rst is high.
- Arbitration:
  - Each cycle, grant at most one source with src_valid=1.
  - Search starts at the pointer and wraps modulo N_SRC.
  - After a grant to source k, the pointer becomes (k+1) mod N_SRC. With no grant, the pointer holds.
- Handshake:
  - src_ready[k]=1 only for the granted source; a transfer occurs on valid&ready at the clock edge.
  - A source must hold valid, addr and data stable until accepted.
  - The block never asserts ready to a non-valid source.
- Output pipeline: registered, latency 1.
  - On the edge after a transfer of (a,d): outreg_en has exactly bit a set for one cycle, and outreg_data[a]=d.
  - All other outreg_data entries hold their previous values.
  - outreg_en=0 in cycles with no transfer.
- r0:
  - Writes to address 0 are accepted (ready asserted, arbitration advances) but dropped.
  - outreg_en[0] is never 1; outreg_data[0] stays 0.
- Scoreboard:
  - iss_valid with iss_addr=a≠0 sets busy[a] at the next edge.
  - A transfer to a clears busy[a] at the same edge the write is registered.
  - Set and clear of the same index in the same cycle: set wins (newer instruction in flight).
  - iss_addr=0 is ignored; busy[0] is always 0.
  - Clear of a non-busy register is legal and has no effect beyond the write.
- Simultaneous requests:
  - All sources valid every cycle → grants rotate 0,1,2,0,...
  - A starved source waits at most N_SRC-1 cycles.
- Same-address writes from different sources are serialized in grant order; the last granted value persists.
- Reset mid-operation:
  - Pending requests are not accepted during rst.
  - Any registered enable pulse is cleared asynchronously.
  - Scoreboard is wiped.
- No storage of write data beyond the single output stage; there is no internal buffering.

Test Plan:
- Reset check: assert rst mid-cycle with outreg_en=32'h0000_0100 → outreg_en, busy, src_ready all 0 immediately. After release, the first grant with all sources valid goes to source 0.
- Single write: ALU valid, addr=5, data=32'hDEAD_BEEF → src_ready[0]=1 that cycle. Next cycle outreg_en=32'h0000_0020, outreg_data[5]=32'hDEAD_BEEF. The following cycle outreg_en=0.
- Round-robin: all three valid continuously, addrs 1/17/3, 6 cycles → grant order 0,1,2,0,1,2. outreg_en sequence 0x2, 0x20000, 0x8, repeating, each delayed by 1 cycle.
- r0 suppression: LSU writes addr=0, data=32'h1234 → src_ready[2]=1 and the pointer advances. outreg_en stays 0; outreg_data[0] stays 0.
- Scoreboard:
  - iss_valid addr=9 → busy=32'h0000_0200 next cycle.
  - FPU writes addr=9 → busy=0 on the edge it is registered.
  - In a later cycle, iss_valid addr=9 together with a writeback to 9 → busy[9] remains 1.
- Backpressure hold: FPU valid with changing competitors; check FPU addr/data are captured exactly once, when src_ready[1]=1, and never when ready=0.
